// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT register offsets, AXI response codes, FSM states and helpers
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wr_state_t;
  typedef enum logic { R_IDLE, R_DATA } rd_state_t;

  typedef enum logic [1:0] { REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME } clint_reg_t;

  // word is addr[15:3]; the registers are all 64-bit aligned
  function automatic clint_reg_t clint_decode(input logic [12:0] word, input logic [2:0] size);
    clint_reg_t sel;
    sel = REG_NONE;
    if (size <= 3'd3) begin
      if (word == CLINT_MSIP_OFF[15:3])          sel = REG_MSIP;
      else if (word == CLINT_MTIMECMP_OFF[15:3]) sel = REG_MTIMECMP;
      else if (word == CLINT_MTIME_OFF[15:3])    sel = REG_MTIME;
    end
    return sel;
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++)
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/clint_timebase.sv
// rtl/clint_timebase.sv - prescaler, mtime/mtimecmp/msip registers and timer interrupt
module clint_timebase
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  clint_reg_t  wr_sel,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        msip,
  output logic        int_m_timer
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime_inc;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign mtime_inc = tick ? mtime + 64'd1 : mtime;

  // A write to mtime merges over the incremented value so unwritten bytes still advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      int_m_timer <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (wr_en && wr_sel == REG_MTIME)
        mtime <= byte_merge(mtime_inc, wr_data, wr_strb);
      else
        mtime <= mtime_inc;
      if (wr_en && wr_sel == REG_MTIMECMP)
        mtimecmp <= byte_merge(mtimecmp, wr_data, wr_strb);
      if (wr_en && wr_sel == REG_MSIP && wr_strb[0])
        msip <= wr_data[0];
      int_m_timer <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/axi_clint_responder.sv
// rtl/axi_clint_responder.sv - AXI4 single-beat slave exposing the CLINT timer registers
module axi_clint_responder
  import clint_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TICK_DIV   = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]            s_awsize,
  input  logic [3:0]            s_awcache,
  input  logic [2:0]            s_awprot,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [7:0]            s_wstrb,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]            s_arsize,
  input  logic [3:0]            s_arcache,
  input  logic [2:0]            s_arprot,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic [63:0]           rdtime,
  output logic                  int_m_timer,
  output logic                  int_m_software
);

  wr_state_t   w_state, w_next;
  rd_state_t   r_state, r_next;
  logic        live;
  logic        aw_held, w_held;
  logic [12:0] aw_word_q;
  logic [2:0]  aw_size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs, do_write;
  clint_reg_t  wr_sel, rd_sel;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic [63:0] rd_val;
  logic [63:0] mtime, mtimecmp;
  logic        msip;

  // Readies stay low until the first clock after reset is released
  assign s_bvalid  = (w_state == W_RESP);
  assign s_awready = live && !aw_held && !s_bvalid;
  assign s_wready  = live && !w_held && !s_bvalid;
  assign s_rvalid  = (r_state == R_DATA);
  assign s_rlast   = s_rvalid;
  assign s_arready = live && !s_rvalid;

  assign aw_hs    = s_awvalid && s_awready;
  assign w_hs     = s_wvalid && s_wready;
  assign ar_hs    = s_arvalid && s_arready;
  assign do_write = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_sel  = aw_hs ? clint_decode(s_awaddr[15:3], s_awsize) : clint_decode(aw_word_q, aw_size_q);
  assign wr_data = w_hs ? s_wdata : wdata_q;
  assign wr_strb = w_hs ? s_wstrb : wstrb_q;
  assign rd_sel  = clint_decode(s_araddr[15:3], s_arsize);

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      REG_MSIP:     rd_val = {63'd0, msip};
      REG_MTIMECMP: rd_val = mtimecmp;
      REG_MTIME:    rd_val = mtime;
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (do_write) w_next = W_RESP;
      W_RESP:  if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word_q <= '0;
      aw_size_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_bresp   <= AXI_RESP_OKAY;
      s_rdata   <= '0;
      s_rresp   <= AXI_RESP_OKAY;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      live    <= 1'b1;
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        s_bresp <= (wr_sel == REG_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_word_q <= s_awaddr[15:3];
          aw_size_q <= s_awsize;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= s_wdata;
          wstrb_q <= s_wstrb;
        end
      end
      if (ar_hs) begin
        s_rdata <= rd_val;
        s_rresp <= (rd_sel == REG_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  clint_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
    .clk         (clk),
    .rst_n       (reset_n),
    .wr_en       (do_write),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .msip        (msip),
    .int_m_timer (int_m_timer)
  );

  assign rdtime         = mtime;
  assign int_m_software = msip;

  logic unused_ok;
  assign unused_ok = ^{s_awaddr[ADDR_WIDTH-1:16], s_awaddr[2:0], s_araddr[ADDR_WIDTH-1:16],
                       s_araddr[2:0], s_awcache, s_awprot, s_arcache, s_arprot, s_wlast};

endmodule

// File: tb/tb_axi_clint_responder.sv
// tb/tb_axi_clint_responder.sv - directed self-checking bench for axi_clint_responder
module tb_axi_clint_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [2:0]  s_awsize;
  logic [3:0]  s_awcache;
  logic [2:0]  s_awprot;
  logic        s_wvalid, s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [2:0]  s_arsize;
  logic [3:0]  s_arcache;
  logic [2:0]  s_arprot;
  logic        s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [63:0] rdtime;
  logic        int_m_timer, int_m_software;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  axi_clint_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TICK_DIV(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
    .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arsize(s_arsize),
    .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .rdtime(rdtime), .int_m_timer(int_m_timer), .int_m_software(int_m_software)
  );

  always #5 clk = ~clk;

  // edge_cnt = number of rising edges seen since reset release
  always @(posedge clk) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d,
                           input logic [7:0] st, output logic [1:0] resp);
    int n;
    s_awaddr = a; s_awsize = sz; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
    n = 0;
    while (!(s_awready && s_wready) && n < 20) begin tick(); n++; end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", s_bvalid, 1);
    resp = s_bresp;
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [2:0] sz,
                          output logic [63:0] d, output logic [1:0] resp);
    int n;
    s_araddr = a; s_arsize = sz; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin tick(); n++; end
    tick();
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid", s_rvalid, 1);
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1; tick(); s_rready = 1'b0;
  endtask

  initial begin
    logic [63:0] d, exp;
    logic [1:0]  r;
    int          n, w_edge;

    reset_n = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_awsize = 0; s_awcache = 0; s_awprot = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 1; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_arsize = 0; s_arcache = 0; s_arprot = 0; s_rready = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_rdtime", rdtime, 0);
    check("rst_timer", int_m_timer, 0);
    check("rst_soft", int_m_software, 0);
    reset_n = 1'b1;

    // Idle 250 cycles: two prescaler wraps
    repeat (250) tick();
    check("idle_rdtime", rdtime, 2);
    check("idle_timer", int_m_timer, 0);
    check("idle_bvalid", s_bvalid, 0);
    check("idle_rvalid", s_rvalid, 0);

    // AW and W together to mtimecmp, upper address bits ignored
    s_awaddr = 32'h0200_4000; s_awsize = 3'd3; s_awvalid = 1;
    s_wdata = 64'd5; s_wstrb = 8'hFF; s_wvalid = 1;
    check("t2_awready", s_awready, 1);
    check("t2_wready", s_wready, 1);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    check("t2_bvalid", s_bvalid, 1);
    check("t2_bresp", s_bresp, 2'b00);
    s_bready = 1; tick(); s_bready = 0;
    check("t2_bvalid_low", s_bvalid, 0);
    n = 0;
    while (rdtime != 64'd5 && n < 400) begin tick(); n++; end
    check("t2_mtime5", rdtime, 5);
    check("t2_timer_lag", int_m_timer, 0);
    tick();
    check("t2_timer_rise", int_m_timer, 1);

    // W three cycles ahead of AW, msip write, bready held off
    s_awaddr = 32'h0; s_awsize = 3'd3;
    s_wdata = 64'd1; s_wstrb = 8'h01; s_wvalid = 1;
    tick();
    s_wvalid = 0;
    check("t3_wready_held", s_wready, 0);
    check("t3_awready_open", s_awready, 1);
    check("t3_no_bvalid", s_bvalid, 0);
    tick(); tick();
    s_awvalid = 1;
    tick();
    s_awvalid = 0;
    check("t3_bvalid", s_bvalid, 1);
    check("t3_bresp", s_bresp, 2'b00);
    check("t3_soft", int_m_software, 1);
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_bvalid", s_bvalid, 1);
      check("t3_hold_awready", s_awready, 0);
      check("t3_hold_wready", s_wready, 0);
      tick();
    end
    check("t3_bvalid_still", s_bvalid, 1);
    s_bready = 1; tick(); s_bready = 0;
    check("t3_bvalid_done", s_bvalid, 0);

    // Read mtime with rready held low
    exp = rdtime;
    s_araddr = 32'h0000_BFF8; s_arsize = 3'd3; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("t4_rvalid", s_rvalid, 1);
      check("t4_rlast", s_rlast, 1);
      check("t4_rdata", s_rdata, exp);
      check("t4_rresp", s_rresp, 2'b00);
      check("t4_arready", s_arready, 0);
      if (i < 4) tick();
    end
    s_rready = 1; tick(); s_rready = 0;
    check("t4_rvalid_done", s_rvalid, 0);
    check("t4_rlast_done", s_rlast, 0);

    // Bad offset / oversize accesses
    axi_read(32'h1234, 3'd4, d, r);
    check("t5_rd_resp", r, 2'b10);
    check("t5_rd_data", d, 0);
    axi_read(32'h1234, 3'd3, d, r);
    check("t5_rd_badoff", r, 2'b10);
    axi_read(32'h4000, 3'd4, d, r);
    check("t5_rd_bigsize", r, 2'b10);
    axi_write(32'h1234, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    check("t5_wr_resp", r, 2'b10);
    axi_write(32'h4000, 3'd4, 64'h0, 8'hFF, r);
    check("t5_wr_bigsize", r, 2'b10);
    axi_read(32'h4000, 3'd3, d, r);
    check("t5_cmp_kept", d, 64'd5);
    check("t5_cmp_resp", r, 2'b00);
    axi_read(32'h0000, 3'd3, d, r);
    check("t5_msip_kept", d, 64'd1);
    check("t5_soft_kept", int_m_software, 1);

    // 32-bit write to upper half of mtimecmp
    axi_write(32'h4004, 3'd2, 64'h0000_0001_0000_0000, 8'hF0, r);
    check("t5b_resp", r, 2'b00);
    axi_read(32'h4000, 3'd3, d, r);
    check("t5b_cmp", d, 64'h0000_0001_0000_0005);
    tick(); tick();
    check("t5b_timer_drop", int_m_timer, 0);

    // mtime write landing on a prescaler wrap edge
    while ((edge_cnt + 1) % 100 != 0) tick();
    s_awaddr = 32'h0000_BFF8; s_awsize = 3'd3; s_awvalid = 1;
    s_wdata = 64'hFFFF_FFFF_FFFF_FFFF; s_wstrb = 8'hFF; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    w_edge = edge_cnt;
    check("t6_bvalid", s_bvalid, 1);
    check("t6_mtime_ones", rdtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t6_timer_lag", int_m_timer, 0);
    s_bready = 1; tick(); s_bready = 0;
    check("t6_timer_on", int_m_timer, 1);
    while (edge_cnt < w_edge + 99) tick();
    check("t6_pre_wrap", rdtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t6_pre_wrap_timer", int_m_timer, 1);
    tick();
    check("t6_wrapped", rdtime, 0);
    check("t6_wrap_timer_lag", int_m_timer, 1);
    tick();
    check("t6_timer_off", int_m_timer, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
